// File: rtl/serial_parity_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_tx
// Description : Shifts a WIDTH-bit word out LSB first, then one parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_tx #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             tx_en,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic             parity_q;
    logic             done_q;
    logic             accept;
    logic             cnt_last;

    assign accept   = (state == S_IDLE) && load;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load) state_nxt = S_DATA;
            S_DATA:   if (cnt_last) state_nxt = S_PARITY;
            S_PARITY: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Parity is fixed at capture time so later data_in changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == S_PARITY);
            if (accept) begin
                shift_q  <= data_in;
                cnt_q    <= '0;
                parity_q <= (^data_in) ^ ODD;
            end else if (state == S_DATA) begin
                shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ready = 1'b0;
        tx    = 1'b0;
        tx_en = 1'b0;
        busy  = 1'b0;
        done  = done_q;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_DATA: begin
                tx    = shift_q[0];
                tx_en = 1'b1;
                busy  = 1'b1;
            end
            S_PARITY: begin
                tx    = parity_q;
                tx_en = 1'b1;
                busy  = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_tx
// Description : Scoreboard bench driving an even- and an odd-parity instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load = 1'b0;
    logic [1:0]   ready_b, tx_b, tx_en_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;

    int m_cnt = 0;
    bit m_done = 1'b0;
    logic [W:0] exp_q0[$];
    logic [W:0] exp_q1[$];
    logic [W:0] col[2];
    int         idx[2];

    always #5 clk = ~clk;

    serial_parity_tx #(.WIDTH(W), .ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
        .ready(ready_b[0]), .tx(tx_b[0]), .tx_en(tx_en_b[0]),
        .busy(busy_b[0]), .done(done_b[0])
    );

    serial_parity_tx #(.WIDTH(W), .ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
        .ready(ready_b[1]), .tx(tx_b[1]), .tx_en(tx_en_b[1]),
        .busy(busy_b[1]), .done(done_b[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: an accepted load occupies the line for W+1 cycles, then done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end else if (load) begin
                m_cnt <= W + 1;
                exp_q0.push_back({1'($countones(data_in) % 2), data_in});
                exp_q1.push_back({1'(($countones(data_in) + 1) % 2), data_in});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            idx[0] = 0;
            idx[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready%0d", k), 32'(ready_b[k]), 32'(m_cnt == 0));
                chk($sformatf("busy%0d", k), 32'(busy_b[k]), 32'(m_cnt != 0));
                chk($sformatf("tx_en%0d", k), 32'(tx_en_b[k]), 32'(m_cnt != 0));
                chk($sformatf("done%0d", k), 32'(done_b[k]), 32'(m_done));
                if (m_cnt == 0) chk($sformatf("idle_tx%0d", k), 32'(tx_b[k]), 32'd0);
                if (tx_en_b[k]) begin
                    col[k][idx[k]] = tx_b[k];
                    idx[k]++;
                    if (idx[k] == W + 1) begin
                        idx[k] = 0;
                        if (k == 0) begin
                            if (exp_q0.size() == 0) chk("frame0_unexpected", 32'd1, 32'd0);
                            else chk("frame0", 32'(col[0]), 32'(exp_q0.pop_front()));
                        end else begin
                            if (exp_q1.size() == 0) chk("frame1_unexpected", 32'd1, 32'd0);
                            else chk("frame1", 32'(col[1]), 32'(exp_q1.pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_cnt != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != 0) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge; leaves load high if keep is set.
    task automatic drive_frame(input logic [W-1:0] d, input bit keep);
        wait_idle();
        load    = 1'b1;
        data_in = d;
        @(negedge clk);
        load    = keep;
        data_in = W'($urandom);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        drive_frame(8'hA5, 1'b0);
        drive_frame(8'h07, 1'b0);
        drive_frame(8'h00, 1'b0);
        drive_frame(8'hFF, 1'b1);
        repeat (4) begin
            data_in = 8'h00;
            @(negedge clk);
        end
        drive_frame(8'h3C, 1'b0);

        drive_frame(8'h96, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_tx%0d", k), 32'(tx_b[k]), 32'd0);
            chk($sformatf("async_tx_en%0d", k), 32'(tx_en_b[k]), 32'd0);
            chk($sformatf("async_busy%0d", k), 32'(busy_b[k]), 32'd0);
            chk($sformatf("async_done%0d", k), 32'(done_b[k]), 32'd0);
            chk($sformatf("async_ready%0d", k), 32'(ready_b[k]), 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_frame(8'h01, 1'b0);

        for (int i = 0; i < 40; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_frame(W'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                data_in = W'($urandom);
                @(negedge clk);
            end
            load = 1'b0;
        end

        load = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("drain0", 32'(exp_q0.size()), 32'd0);
        chk("drain1", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_tx.md
Name: serial_parity_tx

Overview:
Parallel-to-serial transmitter that shifts out a WIDTH-bit word LSB first and appends one parity bit, forming a (WIDTH+1)-bit frame.
It is the sending end of the parity link whose receiving end is the existing XNOR/XOR-based bit-equality and parity-check logic.
It sits between a parallel data source and a one-wire serial channel, with a load/ready handshake on the parallel side.

Parameters:
WIDTH, 8, number of data bits per frame (legal 2..32).
ODD, 0, parity sense: 0 = even (total ones in data+parity even), 1 = odd.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word; sampled only on an accepted load.
load  input  1  request to start a frame.
ready  output  1  high when a load will be accepted (state IDLE).
tx  output  1  serial bit currently driven on the line.
tx_en  output  1  high on every cycle tx carries a frame bit (data or parity).
busy  output  1  high while a frame is in progress (DATA or PARITY).
done  output  1  one-cycle pulse after the parity bit has been sent.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, at any time including mid-frame):
  - state forced to IDLE; shift register, bit counter and parity accumulator cleared.
  - outputs: tx=0, tx_en=0, busy=0, done=0, ready=1.
  - any partial frame is discarded and never resumed.
- States:
  - IDLE: ready=1, tx=0, tx_en=0, busy=0.
    - On a rising edge with load=1: capture data_in into the shift register; parity register = XOR-reduce(data_in) ^ ODD; counter=0; go to DATA.
    - With load=0: stay in IDLE.
  - DATA: tx=shift[0], tx_en=1, busy=1, ready=0.
    - Each edge: shift right by one, counter+1.
    - After exactly WIDTH DATA cycles (counter reaches WIDTH-1 and the edge is taken): go to PARITY.
  - PARITY: tx=parity register, tx_en=1, busy=1, ready=0. Next edge: go to IDLE and assert done for that one IDLE cycle.
- Latency: the first data bit appears on tx in the cycle after the accepting edge. A frame is WIDTH+1 tx_en cycles. Accept-to-accept period is at least WIDTH+2 cycles.
- load while busy=1 is ignored: no capture and no effect on the frame in flight. data_in changes during a frame have no effect.
- Back-to-back: load=1 in the done cycle (IDLE, ready=1) is accepted. done and ready are both high in that cycle.
- All outputs are registered or decoded from state only. No combinational path from load or data_in to any output.
- Parity arithmetic:
  - even: tx_parity = XOR of all data bits.
  - odd: that value inverted.
  - all-zero data gives parity 0 (even) or 1 (odd).
- Counter width is ceil(log2(WIDTH)) bits. It must not wrap within a frame.

Test Plan:
1. WIDTH=8, ODD=0, load with data_in=8'hA5 -> tx over 9 tx_en cycles = 1,0,1,0,0,1,0,1 then parity 0; done pulses once in the following cycle; ready returns to 1 in that same cycle.
2. WIDTH=8, ODD=0, data_in=8'h07 -> bits 1,1,1,0,0,0,0,0, parity 1. With ODD=1 and data_in=8'h00 -> 8 zeros, parity 1.
3. Load 8'hFF, then hold load=1 and change data_in to 8'h00 during the DATA phase -> the frame stays 8 ones plus parity 0; no second frame starts until the done cycle.
4. Assert load=1 in the done cycle with 8'h3C -> next frame starts on the next cycle with no gap beyond that IDLE cycle; bits 0,0,1,1,1,1,0,0, parity 0.
5. Pull rst_n low asynchronously during bit 4 of a frame -> tx, tx_en, busy and done go to 0 and ready to 1 immediately, without waiting for a clock edge; after release, a new load of 8'h01 yields 1,0,0,0,0,0,0,0, parity 1.
6. Hold load=0 for 20 cycles after reset -> tx=0, tx_en=0, busy=0, done=0 and ready=1 throughout.
